// File: rtl/pkt_wrr_arbiter_pkg.sv
// Shared types and helpers for the weighted round-robin packet arbiter.
package pkt_wrr_arbiter_pkg;

    // IDLE: free to arbitrate; PKT: output locked to the owner until its last beat
    typedef enum logic {
        IDLE = 1'b0,
        PKT  = 1'b1
    } state_e;

    // Index type for the default four-source configuration
    localparam int unsigned DefaultNumIn = 4;
    typedef logic [$clog2(DefaultNumIn)-1:0] idx_t;

    // Next index in cyclic order, wrapping from numIn-1 back to 0
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned numIn);
        return (idx >= numIn - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/pkt_wrr_arbiter_cyclic_prio_enc.sv
// Cyclic priority encoder: first set request at or after the start pointer,
// wrapping around; reports the pointer itself when nothing is requesting.
module cyclic_prio_enc #(
    parameter int unsigned NumIn = 4,
    parameter int unsigned IdxW  = 2
) (
    input  logic [NumIn-1:0] req_i,
    input  logic [IdxW-1:0]  ptr_i,
    output logic [IdxW-1:0]  idx_o,
    output logic             found_o
);

    int unsigned     cand;
    logic [IdxW-1:0] candIdx;

    // Walk NumIn positions starting at the pointer and keep the first hit
    always_comb begin
        idx_o   = ptr_i;
        found_o = 1'b0;
        cand    = 0;
        candIdx = '0;
        for (int unsigned k = 0; k < NumIn; k++) begin
            cand = 32'(ptr_i) + k;
            if (cand >= NumIn) begin
                cand = cand - NumIn;
            end
            candIdx = IdxW'(cand);
            if (!found_o && req_i[candIdx]) begin
                idx_o   = candIdx;
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pkt_wrr_arbiter.sv
// Weighted round-robin packet arbiter: multi-beat packets are kept atomic and
// each source may send up to its weight in consecutive packets per turn.
module pkt_wrr_arbiter
    import pkt_wrr_arbiter_pkg::*;
#(
    parameter int unsigned NumIn       = 4,
    parameter int unsigned DataWidth   = 32,
    parameter int unsigned WeightWidth = 4,
    localparam int unsigned IdxW       = $clog2(NumIn)
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         flush_i,
    input  logic [NumIn*WeightWidth-1:0] weight_i,
    input  logic [NumIn-1:0]             req_i,
    input  logic [NumIn-1:0]             last_i,
    input  logic [NumIn*DataWidth-1:0]   data_i,
    output logic [NumIn-1:0]             gnt_o,
    output logic                         req_o,
    output logic                         last_o,
    output logic [DataWidth-1:0]         data_o,
    output logic [IdxW-1:0]              idx_o,
    input  logic                         gnt_i
);

    state_e                 state_q, state_d;
    logic [IdxW-1:0]        owner_q, owner_d;
    logic [IdxW-1:0]        ptr_q, ptr_d;
    logic [WeightWidth-1:0] used_q, used_d;

    logic [IdxW-1:0]        encIdx;
    logic                   encFound;
    logic [IdxW-1:0]        sel;
    logic                   reqSel;
    logic                   xfer;
    logic [WeightWidth-1:0] weightSel;
    logic [WeightWidth-1:0] wEff;
    logic [WeightWidth-1:0] usedNext;

    cyclic_prio_enc #(
        .NumIn (NumIn),
        .IdxW  (IdxW)
    ) u_enc (
        .req_i   (req_i),
        .ptr_i   (ptr_q),
        .idx_o   (encIdx),
        .found_o (encFound)
    );

    // Selection follows the lock while a packet is open, otherwise the encoder
    always_comb begin
        sel    = (state_q == PKT) ? owner_q : encIdx;
        reqSel = (state_q == PKT) ? req_i[owner_q] : encFound;
        req_o  = reqSel & ~flush_i;
        last_o = last_i[sel];
        data_o = data_i[DataWidth*int'(sel) +: DataWidth];
        idx_o  = sel;
        xfer   = req_o & gnt_i;
        gnt_o  = '0;
        if (!flush_i) begin
            gnt_o[sel] = gnt_i & reqSel;
        end
    end

    // Turn accounting: a weight of zero still allows one packet per turn
    always_comb begin
        weightSel = weight_i[WeightWidth*int'(sel) +: WeightWidth];
        wEff      = (weightSel == '0) ? WeightWidth'(1) : weightSel;
        usedNext  = (sel == ptr_q) ? used_q + 1'b1 : WeightWidth'(1);
    end

    // Next-state: lock on a non-last beat, release and rotate on the last beat
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        used_d  = used_q;
        if (flush_i) begin
            state_d = IDLE;
            owner_d = '0;
            ptr_d   = '0;
            used_d  = '0;
        end else if (xfer) begin
            if (!last_o) begin
                state_d = PKT;
                owner_d = sel;
            end else begin
                state_d = IDLE;
                if (usedNext >= wEff) begin
                    ptr_d  = IdxW'(wrap_inc(32'(sel), NumIn));
                    used_d = '0;
                end else begin
                    ptr_d  = sel;
                    used_d = usedNext;
                end
            end
        end
    end

    // Arbiter state registers with asynchronous reset dropping any lock
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            used_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            used_q  <= used_d;
        end
    end

endmodule

// File: tb/tb_pkt_wrr_arbiter.sv
// Directed testbench for pkt_wrr_arbiter with hand-computed expectations.
module tb_pkt_wrr_arbiter;
    import pkt_wrr_arbiter_pkg::*;

    localparam int unsigned NumIn       = 4;
    localparam int unsigned DataWidth   = 32;
    localparam int unsigned WeightWidth = 4;

    logic                         clk_i = 1'b0;
    logic                         rst_ni;
    logic                         flush_i;
    logic [NumIn*WeightWidth-1:0] weight_i;
    logic [NumIn-1:0]             req_i;
    logic [NumIn-1:0]             last_i;
    logic [NumIn*DataWidth-1:0]   data_i;
    logic [NumIn-1:0]             gnt_o;
    logic                         req_o;
    logic                         last_o;
    logic [DataWidth-1:0]         data_o;
    idx_t                         idx_o;
    logic                         gnt_i;

    int nCompared = 0;
    int nMismatch = 0;

    localparam logic [NumIn*DataWidth-1:0] DefaultData =
        {32'hDA7A_0003, 32'hDA7A_0002, 32'hDA7A_0001, 32'hDA7A_0000};

    pkt_wrr_arbiter #(
        .NumIn       (NumIn),
        .DataWidth   (DataWidth),
        .WeightWidth (WeightWidth)
    ) dut (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .flush_i  (flush_i),
        .weight_i (weight_i),
        .req_i    (req_i),
        .last_i   (last_i),
        .data_i   (data_i),
        .gnt_o    (gnt_o),
        .req_o    (req_o),
        .last_o   (last_o),
        .data_o   (data_o),
        .idx_o    (idx_o),
        .gnt_i    (gnt_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_flush(input string tag);
        flush_i = 1'b1;
        req_i   = 4'b0000;
        #1;
        nCompared++;
        if ({req_o, gnt_o} !== 5'b0) begin
            nMismatch++;
            $display("[TB] FAIL %s_flush {req_o,gnt_o} got %b expected 00000", tag, {req_o, gnt_o});
        end
        tick();
        flush_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_ni   = 1'b0;
        flush_i  = 1'b0;
        req_i    = '0;
        last_i   = '0;
        gnt_i    = 1'b1;
        weight_i = '0;
        data_i   = DefaultData;
        #2;
        nCompared++;
        if ({req_o, gnt_o, idx_o, last_o} !== 8'b0) begin
            nMismatch++;
            $display("[TB] FAIL reset_outputs {req,gnt,idx,last} got %b expected 00000000", {req_o, gnt_o, idx_o, last_o});
        end
        nCompared++;
        if (data_o !== 32'hDA7A_0000) begin
            nMismatch++;
            $display("[TB] FAIL reset_data got %h expected DA7A0000", data_o);
        end
        rst_ni = 1'b1;
        tick();
    endtask

    task automatic test_round_robin();
        idx_t expIdx [4] = '{2'd1, 2'd2, 2'd1, 2'd2};
        weight_i = '0;
        req_i    = 4'b0110;
        last_i   = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            #1;
            nCompared++;
            if ({gnt_o, idx_o} !== {4'b0001 << expIdx[i], expIdx[i]}) begin
                nMismatch++;
                $display("[TB] FAIL rr_%0d {gnt,idx} got %b expected %b", i, {gnt_o, idx_o}, {4'b0001 << expIdx[i], expIdx[i]});
            end
            tick();
        end
    endtask

    task automatic test_weights();
        idx_t expIdx [8] = '{2'd0, 2'd0, 2'd0, 2'd2, 2'd0, 2'd0, 2'd0, 2'd2};
        do_flush("weights");
        weight_i = 16'h1113;
        req_i    = 4'b0101;
        last_i   = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            #1;
            nCompared++;
            if ({gnt_o, idx_o} !== {4'b0001 << expIdx[i], expIdx[i]}) begin
                nMismatch++;
                $display("[TB] FAIL wrr_%0d {gnt,idx} got %b expected %b", i, {gnt_o, idx_o}, {4'b0001 << expIdx[i], expIdx[i]});
            end
            tick();
        end
        weight_i = '0;
    endtask

    task automatic test_packet_lock();
        do_flush("lock");
        req_i  = 4'b0001;
        last_i = 4'b0001;
        #1;
        nCompared++;
        if ({gnt_o, idx_o} !== 6'b0001_00) begin
            nMismatch++;
            $display("[TB] FAIL lock_pre {gnt,idx} got %b expected 000100", {gnt_o, idx_o});
        end
        tick();
        req_i = 4'b0011;
        for (int b = 0; b < 4; b++) begin
            last_i          = {2'b00, (b == 3), 1'b1};
            data_i[63:32]   = 32'hB000_0000 + 32'(b);
            #1;
            nCompared++;
            if ({gnt_o, idx_o, req_o, last_o} !== {4'b0010, 2'd1, 1'b1, (b == 3)}) begin
                nMismatch++;
                $display("[TB] FAIL lock_beat%0d {gnt,idx,req,last} got %b expected %b", b, {gnt_o, idx_o, req_o, last_o}, {4'b0010, 2'd1, 1'b1, (b == 3)});
            end
            nCompared++;
            if (data_o !== 32'hB000_0000 + 32'(b)) begin
                nMismatch++;
                $display("[TB] FAIL lock_data%0d got %h expected %h", b, data_o, 32'hB000_0000 + 32'(b));
            end
            tick();
        end
        #1;
        nCompared++;
        if ({gnt_o, idx_o} !== 6'b0001_00) begin
            nMismatch++;
            $display("[TB] FAIL lock_after {gnt,idx} got %b expected 000100", {gnt_o, idx_o});
        end
        tick();
        data_i = DefaultData;
    endtask

    task automatic test_bubble();
        do_flush("bubble");
        req_i  = 4'b0100;
        last_i = 4'b0000;
        #1;
        nCompared++;
        if ({gnt_o, idx_o} !== 6'b0100_10) begin
            nMismatch++;
            $display("[TB] FAIL bubble_start {gnt,idx} got %b expected 010010", {gnt_o, idx_o});
        end
        tick();
        req_i  = 4'b1000;
        last_i = 4'b1000;
        for (int i = 0; i < 2; i++) begin
            #1;
            nCompared++;
            if ({req_o, gnt_o, idx_o} !== 7'b0_0000_10) begin
                nMismatch++;
                $display("[TB] FAIL bubble_%0d {req,gnt,idx} got %b expected 0000010", i, {req_o, gnt_o, idx_o});
            end
            tick();
        end
        req_i  = 4'b1100;
        last_i = 4'b1100;
        #1;
        nCompared++;
        if ({gnt_o, idx_o, last_o} !== 7'b0100_10_1) begin
            nMismatch++;
            $display("[TB] FAIL bubble_end {gnt,idx,last} got %b expected 0100101", {gnt_o, idx_o, last_o});
        end
        tick();
        req_i = 4'b1000;
        #1;
        nCompared++;
        if ({gnt_o, idx_o} !== 6'b1000_11) begin
            nMismatch++;
            $display("[TB] FAIL bubble_next {gnt,idx} got %b expected 100011", {gnt_o, idx_o});
        end
        tick();
    endtask

    task automatic test_back_to_back_stall();
        do_flush("stall");
        req_i        = 4'b0011;
        last_i       = 4'b0010;
        data_i[31:0] = 32'h0000_0100;
        gnt_i        = 1'b1;
        #1;
        nCompared++;
        if ({gnt_o, data_o} !== {4'b0001, 32'h0000_0100}) begin
            nMismatch++;
            $display("[TB] FAIL stall_beat1 {gnt,data} got %h expected 1_00000100", {gnt_o, data_o});
        end
        tick();
        data_i[31:0] = 32'h0000_0101;
        gnt_i        = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            nCompared++;
            if ({req_o, gnt_o, idx_o} !== 7'b1_0000_00) begin
                nMismatch++;
                $display("[TB] FAIL stall_%0d {req,gnt,idx} got %b expected 1000000", i, {req_o, gnt_o, idx_o});
            end
            nCompared++;
            if (data_o !== 32'h0000_0101) begin
                nMismatch++;
                $display("[TB] FAIL stall_data%0d got %h expected 00000101", i, data_o);
            end
            tick();
        end
        gnt_i = 1'b1;
        #1;
        nCompared++;
        if ({gnt_o, data_o} !== {4'b0001, 32'h0000_0101}) begin
            nMismatch++;
            $display("[TB] FAIL stall_beat2 {gnt,data} got %h expected 1_00000101", {gnt_o, data_o});
        end
        tick();
        data_i[31:0] = 32'h0000_0102;
        last_i       = 4'b0011;
        #1;
        nCompared++;
        if ({gnt_o, last_o, data_o} !== {4'b0001, 1'b1, 32'h0000_0102}) begin
            nMismatch++;
            $display("[TB] FAIL stall_beat3 {gnt,last,data} got %h expected %h", {gnt_o, last_o, data_o}, {4'b0001, 1'b1, 32'h0000_0102});
        end
        tick();
        #1;
        nCompared++;
        if ({gnt_o, idx_o} !== 6'b0010_01) begin
            nMismatch++;
            $display("[TB] FAIL stall_next {gnt,idx} got %b expected 001001", {gnt_o, idx_o});
        end
        tick();
        data_i = DefaultData;
    endtask

    task automatic test_flush_mid_packet();
        do_flush("midflush");
        req_i  = 4'b0100;
        last_i = 4'b0100;
        #1;
        nCompared++;
        if ({gnt_o, idx_o} !== 6'b0100_10) begin
            nMismatch++;
            $display("[TB] FAIL midflush_pre {gnt,idx} got %b expected 010010", {gnt_o, idx_o});
        end
        tick();
        req_i  = 4'b1001;
        last_i = 4'b0001;
        #1;
        nCompared++;
        if ({gnt_o, idx_o} !== 6'b1000_11) begin
            nMismatch++;
            $display("[TB] FAIL midflush_beat1 {gnt,idx} got %b expected 100011", {gnt_o, idx_o});
        end
        tick();
        flush_i = 1'b1;
        #1;
        nCompared++;
        if ({req_o, gnt_o} !== 5'b0) begin
            nMismatch++;
            $display("[TB] FAIL midflush_cycle {req,gnt} got %b expected 00000", {req_o, gnt_o});
        end
        tick();
        flush_i = 1'b0;
        #1;
        nCompared++;
        if ({gnt_o, idx_o} !== 6'b0001_00) begin
            nMismatch++;
            $display("[TB] FAIL midflush_after {gnt,idx} got %b expected 000100", {gnt_o, idx_o});
        end
        tick();
    endtask

    task automatic test_async_reset();
        do_flush("areset");
        req_i  = 4'b0010;
        last_i = 4'b0000;
        #1;
        nCompared++;
        if ({gnt_o, idx_o} !== 6'b0010_01) begin
            nMismatch++;
            $display("[TB] FAIL areset_start {gnt,idx} got %b expected 001001", {gnt_o, idx_o});
        end
        tick();
        req_i = 4'b0011;
        #1;
        nCompared++;
        if ({gnt_o, idx_o} !== 6'b0010_01) begin
            nMismatch++;
            $display("[TB] FAIL areset_locked {gnt,idx} got %b expected 001001", {gnt_o, idx_o});
        end
        #1;
        rst_ni = 1'b0;
        #1;
        nCompared++;
        if ({gnt_o, idx_o} !== 6'b0001_00) begin
            nMismatch++;
            $display("[TB] FAIL areset_drop {gnt,idx} got %b expected 000100", {gnt_o, idx_o});
        end
        rst_ni = 1'b1;
        tick();
        req_i = '0;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_weights();
        test_packet_lock();
        test_bubble();
        test_back_to_back_stall();
        test_flush_mid_packet();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule

// File: doc/pkt_wrr_arbiter.md
# pkt_wrr_arbiter

Weighted round-robin arbiter that shares one valid/ready stream sink between `NumIn` packet sources. A granted packet is never interleaved: once its first beat transfers, the source holds the output until its `last` beat transfers. Each source may send up to `weight_i[i]` consecutive packets before priority rotates. It sits in front of shared resources such as a memory port or NoC injection port, where the plain round-robin tree cannot keep multi-beat bursts atomic.

## Interface
Parameters:
- `NumIn`, 4: number of sources, ≥2.
- `DataWidth`, 32: payload width.
- `WeightWidth`, 4: width of each weight field.

Ports:
- `clk_i`, in, 1: clock.
- `rst_ni`, in, 1: reset, asynchronous, active-low.
- `flush_i`, in, 1: synchronous clear of arbiter state.
- `weight_i`, in, `NumIn`×`WeightWidth`: packets per turn per source; 0 is treated as 1.
- `req_i`, in, `NumIn`: source valid.
- `last_i`, in, `NumIn`: beat is the final beat of its packet.
- `data_i`, in, `NumIn`×`DataWidth`: source payload.
- `gnt_o`, out, `NumIn`: source ready, one-hot or zero.
- `req_o`, out, 1: sink valid.
- `last_o`, out, 1: selected `last_i`.
- `data_o`, out, `DataWidth`: selected payload.
- `idx_o`, out, `$clog2(NumIn)`: selected source index.
- `gnt_i`, in, 1: sink ready.

## Operation
- State registers:
  - `state_q` ∈ {IDLE, PKT}.
  - `owner_q`: index locked for the current packet.
  - `ptr_q`: highest-priority index.
  - `used_q`: packets already consumed by `ptr_q` in its current turn.
- Selection `sel`:
  - IDLE: first index i with `req_i[i]=1`, searched cyclically from `ptr_q` (`ptr_q`, `ptr_q+1`, … wrapping at `NumIn-1`).
  - PKT: `owner_q`, regardless of other requests.
- Outputs:
  - `req_o = req_i[sel]`; `data_o`, `last_o` and `idx_o` are multiplexed by `sel`.
  - `gnt_o[sel] = gnt_i & req_i[sel]`; all other `gnt_o` bits are 0.
  - IDLE with no request: `req_o=0`, `gnt_o='0`, `idx_o=ptr_q`.
- Transfer condition: `req_o & gnt_i`.
- Transfer with `last_o=0`:
  - IDLE → PKT, `owner_q<=sel`.
  - In PKT, stay in PKT.
- Transfer with `last_o=1` (packet end):
  - State → IDLE.
  - `used = (sel==ptr_q) ? used_q+1 : 1`.
  - `w = max(weight_i[sel],1)`, sampled in the packet-end cycle.
  - If `used ≥ w`: `ptr_q <= (sel==NumIn-1) ? 0 : sel+1`, `used_q<=0`.
  - Otherwise: `ptr_q<=sel`, `used_q<=used`.
- Single-beat packets go IDLE → IDLE and never enter PKT.
- In PKT, the owner may drop `req_i` mid-packet (bubble). The lock holds and no other source is granted.
- `flush_i` cycle:
  - `gnt_o='0`, `req_o=0`, no transfer.
  - Next state: IDLE, `ptr_q=0`, `used_q=0`, `owner_q=0`.
  - A flush mid-packet abandons the packet.
- `flush_i` overrides a simultaneous transfer.
- Reset:
  - State: IDLE, `ptr_q=0`, `used_q=0`, `owner_q=0`.
  - Outputs with `req_i='0`: `req_o=0`, `gnt_o='0`, `last_o=0`, `idx_o=0`, `data_o=data_i[0]`.
- Reset asserted mid-packet drops the lock immediately (asynchronous).
- Width rule: `used_q` is `WeightWidth` bits and never exceeds `w-1`, so no overflow.

## Timing
- Zero-latency combinational paths: `req_i`/`last_i`/`data_i` → `req_o`/`last_o`/`data_o`/`idx_o`, and `gnt_i` → `gnt_o`. The first beat transfers in the cycle a request appears.
- State updates on the rising `clk_i` edge after a transfer. A new arbitration decision is valid the cycle after a packet end.
- Throughput: one beat per cycle, including back-to-back packets from different sources.
- Sources must hold `data_i`/`last_i` stable while `req_i=1` and `gnt_o=0`.
- Changing `weight_i` affects only the next packet end.

## Structure
- Package `pkt_wrr_arbiter_pkg`:
  - `state_e` enum {IDLE, PKT}.
  - `idx_t` typedef.
  - Function `wrap_inc(idx)`.
- Sub-module `cyclic_prio_enc`:
  - Inputs: `NumIn`-bit request vector, start pointer.
  - Outputs: first-set index searched cyclically from the pointer, and a `found` flag.
  - Purely combinational; instantiated once.
- Top level: state registers, used/pointer update, output mux.

## Test plan
- Reset, all requests low → `req_o=0`, `gnt_o=0000`, `idx_o=0`. Then `req_i=0110`, single-beat packets, `weight=1` → grants in order 1,2,1,2.
- Weights {3,1,1,1}, sources 0 and 2 requesting continuously, single-beat packets → `idx_o` sequence 0,0,0,2,0,0,0,2.
- Source 1 sends a 4-beat packet while source 0 requests throughout → `gnt_o[0]=0` for all 4 beats. Source 0 is granted in the cycle after `last`.
- Mid-packet bubble: owner 2 drops `req_i[2]` for 2 cycles with `req_i[3]=1` → `req_o=0`, `gnt_o=0000`, and the lock stays on 2.
- `gnt_i=0` on beat 2 of a 3-beat packet for 5 cycles → `data_o` stable, then the packet completes with no interleaving.
- `flush_i` pulse in beat 2 of a packet from source 3 (`ptr_q=3`) → `gnt_o=0000` in the flush cycle. Next cycle `ptr_q=0`, IDLE, and the lowest requesting index ≥0 is granted.
